// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU datapath, the result stage and its consumer.
// The slave view belongs to the result stage; the master view is the
// producer/consumer side that drives inputs and accepts results.
interface alu_result_stage_if #(
  parameter int N  = 32,
  parameter int CW = 16
);
  // producer -> stage
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_res;
  logic          in_cout;
  logic          in_a_msb;
  logic          in_b_msb;
  logic          in_arith;
  logic          in_sub;
  // stage -> consumer
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_res;
  logic [3:0]    out_flags;
  logic [CW-1:0] out_count;

  modport slave (
    input  in_valid, in_res, in_cout, in_a_msb, in_b_msb, in_arith, in_sub,
    input  out_ready,
    output in_ready,
    output out_valid, out_res, out_flags, out_count
  );

  modport master (
    output in_valid, in_res, in_cout, in_a_msb, in_b_msb, in_arith, in_sub,
    output out_ready,
    input  in_ready,
    input  out_valid, out_res, out_flags, out_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: registers each ALU result together with its Z/N/C/V
// flags and hands it downstream over valid/ready. A two-entry skid buffer
// (main register M + skid register S) keeps in_ready a pure state decode,
// so it never depends combinationally on out_ready, while still sustaining
// one result per cycle. Completed output transfers are counted (wrapping).
module alu_result_stage #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input logic              clk,
  input logic              rst,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Flags packed as {Z, N, C, V}. Carry and overflow only make sense for
  // add/sub, so they are masked for logical ops. Overflow uses the effective
  // B sign (inverted for subtract): operands of equal sign producing a
  // result of different sign means the signed result wrapped.
  function automatic logic [3:0] calc_flags(
    input logic [N-1:0] res,
    input logic         cout,
    input logic         a_msb,
    input logic         b_msb,
    input logic         arith,
    input logic         sub
  );
    logic z;
    logic n;
    logic c;
    logic v;
    logic b_eff;
    b_eff = b_msb ^ sub;
    z     = (res == {N{1'b0}});
    n     = res[N-1];
    c     = arith & cout;
    v     = arith & (a_msb == b_eff) & (res[N-1] != a_msb);
    return {z, n, c, v};
  endfunction

  state_t        state_r;
  logic [N-1:0]  m_res_r;
  logic [3:0]    m_flags_r;
  logic [N-1:0]  s_res_r;
  logic [3:0]    s_flags_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic [CW-1:0] count_r;

  logic          in_fire_s;
  logic          out_fire_s;
  logic [3:0]    in_flags_s;

  // Handshake qualifiers and flags for the result currently offered.
  always_comb begin
    in_fire_s  = bus.in_valid & in_ready_r;
    out_fire_s = out_valid_r & bus.out_ready;
    in_flags_s = calc_flags(bus.in_res, bus.in_cout, bus.in_a_msb,
                            bus.in_b_msb, bus.in_arith, bus.in_sub);
  end

  // in_ready is held low while reset is applied and otherwise mirrors the
  // registered state decode, so it is high in the first cycle after reset.
  assign bus.in_ready  = in_ready_r & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_res   = m_res_r;
  assign bus.out_flags = m_flags_r;
  assign bus.out_count = count_r;

  // Skid-buffer state machine: owns M, S and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      m_res_r     <= {N{1'b0}};
      m_flags_r   <= 4'b0000;
      s_res_r     <= {N{1'b0}};
      s_flags_r   <= 4'b0000;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            m_res_r     <= bus.in_res;
            m_flags_r   <= in_flags_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire_s && !out_fire_s) begin
            // consumer stalled: park the newcomer behind M
            s_res_r    <= bus.in_res;
            s_flags_r  <= in_flags_s;
            state_r    <= FULL;
            in_ready_r <= 1'b0;
          end else if (!in_fire_s && out_fire_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end else if (in_fire_s && out_fire_s) begin
            // streaming: replace the departing result directly
            m_res_r   <= bus.in_res;
            m_flags_r <= in_flags_s;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            m_res_r    <= s_res_r;
            m_flags_r  <= s_flags_r;
            state_r    <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Delivered-result counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (out_fire_s) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vectors from a table, then
// hand-written skid, streaming, mid-operation reset and counter-wrap sequences.
module tb_alu_result_stage;

  logic clk;
  logic rst;

  alu_result_stage_if #(.N(32), .CW(16)) bus ();
  alu_result_stage_if #(.N(32), .CW(4))  bus2 ();

  alu_result_stage #(.N(32), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_result_stage #(.N(32), .CW(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        a_msb;
    logic        b_msb;
    logic        arith;
    logic        sub;
    logic [3:0]  flags;
  } vec_t;

  vec_t        vecs [8];
  int          n_tests;
  int          n_fail;
  logic [31:0] src [128];
  int          nsrc;
  int          idx;
  logic [31:0] got [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: log transfers seen just before the edge, then step past it.
  task automatic tick();
    logic fire_in;
    #1;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_res);
    fire_in = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (fire_in) idx++;
  endtask

  task automatic drive_src();
    bus.in_valid = (idx < nsrc);
    bus.in_res   = (idx < nsrc) ? src[idx] : 32'h0;
    bus.in_cout  = 1'b0;
    bus.in_a_msb = 1'b0;
    bus.in_b_msb = 1'b0;
    bus.in_arith = 1'b0;
    bus.in_sub   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
    idx  = 0;
    nsrc = 0;
    #1;
  endtask

  initial begin
    int mism;
    int ready_low;
    int acc;
    int cyc;
    logic [3:0] held_flags;

    n_tests = 0;
    n_fail  = 0;
    idx     = 0;
    nsrc    = 0;
    rst     = 1'b1;
    bus.in_valid = 1'b0; bus.in_res = 32'h0; bus.in_cout = 1'b0;
    bus.in_a_msb = 1'b0; bus.in_b_msb = 1'b0; bus.in_arith = 1'b0;
    bus.in_sub = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_res = 32'h0; bus2.in_cout = 1'b0;
    bus2.in_a_msb = 1'b0; bus2.in_b_msb = 1'b0; bus2.in_arith = 1'b0;
    bus2.in_sub = 1'b0; bus2.out_ready = 1'b0;

    //             res           cout  a     b     arith sub   {Z,N,C,V}
    vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101};
    vecs[2] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[4] = '{32'h0000_0005, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[5] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010};
    vecs[6] = '{32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[7] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011};

    // reset behaviour
    tick();
    check("in_ready_during_rst", {63'd0, bus.in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
    check("out_valid_after_rst", {63'd0, bus.out_valid}, 64'd0);
    check("count_after_rst", {48'd0, bus.out_count}, 64'd0);

    // flag table, one result at a time from EMPTY
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_res    = vecs[i].res;
      bus.in_cout   = vecs[i].cout;
      bus.in_a_msb  = vecs[i].a_msb;
      bus.in_b_msb  = vecs[i].b_msb;
      bus.in_arith  = vecs[i].arith;
      bus.in_sub    = vecs[i].sub;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
      check($sformatf("vec%0d_res", i), {32'd0, bus.out_res}, {32'd0, vecs[i].res});
      check($sformatf("vec%0d_flags", i), {60'd0, bus.out_flags}, {60'd0, vecs[i].flags});
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_count", i), {48'd0, bus.out_count}, 64'(i + 1));
      check($sformatf("vec%0d_drained", i), {63'd0, bus.out_valid}, 64'd0);
    end

    // backpressure into the skid register
    do_reset();
    src[0] = 32'h1; src[1] = 32'h2; src[2] = 32'h3;
    nsrc = 3;
    drive_src();
    tick(); drive_src();
    check("skid_m_after1", {32'd0, bus.out_res}, 64'h1);
    check("skid_ready_after1", {63'd0, bus.in_ready}, 64'd1);
    tick(); drive_src();
    check("skid_ready_after2", {63'd0, bus.in_ready}, 64'd0);
    check("skid_m_after2", {32'd0, bus.out_res}, 64'h1);
    held_flags = bus.out_flags;
    tick(); drive_src();
    check("skid_third_not_taken", 64'(idx), 64'd2);
    check("skid_m_stable", {32'd0, bus.out_res}, 64'h1);
    check("skid_flags_stable", {60'd0, bus.out_flags}, {60'd0, held_flags});
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(); drive_src();
    end
    check("skid_out_count", 64'(got.size()), 64'd3);
    mism = 0;
    for (int i = 0; i < got.size() && i < 3; i++)
      if (got[i] !== src[i]) mism++;
    check("skid_order", 64'(mism), 64'd0);
    check("skid_counter", {48'd0, bus.out_count}, 64'd3);

    // continuous streaming through ONE
    do_reset();
    nsrc = 100;
    for (int i = 0; i < 100; i++) src[i] = $urandom;
    bus.out_ready = 1'b1;
    drive_src();
    ready_low = 0;
    for (int c = 0; c < 101; c++) begin
      if (!bus.in_ready && idx < nsrc) ready_low++;
      tick(); drive_src();
      if (c == 0) check("stream_latency", {63'd0, bus.out_valid}, 64'd1);
    end
    check("stream_ready_low", 64'(ready_low), 64'd0);
    check("stream_out_count", 64'(got.size()), 64'd100);
    mism = 0;
    for (int i = 0; i < got.size() && i < 100; i++)
      if (got[i] !== src[i]) mism++;
    check("stream_order", 64'(mism), 64'd0);
    check("stream_counter", {48'd0, bus.out_count}, 64'd100);
    check("stream_drained", {63'd0, bus.out_valid}, 64'd0);

    // reset while FULL
    do_reset();
    src[0] = 32'hA; src[1] = 32'hB; src[2] = 32'hC;
    nsrc = 3;
    bus.out_ready = 1'b1;
    drive_src();
    tick(); drive_src();
    tick(); drive_src();
    bus.out_ready = 1'b0;
    tick(); drive_src();
    check("full_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("full_count", {48'd0, bus.out_count}, 64'd1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_res   = 32'hDEAD_BEEF;
    tick();
    check("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_count", {48'd0, bus.out_count}, 64'd0);
    check("midrst_res", {32'd0, bus.out_res}, 64'd0);
    check("midrst_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    got.delete();
    #1;
    check("midrst_ready_after", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("midrst_no_stale", 64'(got.size()), 64'd0);
    check("midrst_count_after", {48'd0, bus.out_count}, 64'd0);

    // 4-bit counter wraps after 16 transfers
    do_reset();
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 17 && cyc < 60) begin
      bus2.in_res = 32'(acc + 1);
      #1;
      if (bus2.in_valid && bus2.in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
      bus2.in_valid = (acc < 17);
    end
    bus2.in_valid = 1'b0;
    tick(); tick(); tick();
    check("wrap_accepts", 64'(acc), 64'd17);
    check("wrap_count", {60'd0, bus2.out_count}, 64'd1);
    check("wrap_drained", {63'd0, bus2.out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
